// File: rtl/wifi_tx_pkg.sv
// wifi_tx_pkg: shared rate codes, generators and puncture masks for the 802.11a tx datapath.
// CONV_TAIL_INSERT_EN adds the TAIL encoder state.
package wifi_tx_pkg;
  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;
  localparam logic [6:0] G0_DEFAULT = 7'b1011011;
  localparam logic [6:0] G1_DEFAULT = 7'b1111001;
  localparam int TAIL_BITS = 6;
  // {keep A, keep B} per phase, phase 0 in the low pair
  localparam logic [5:0] KEEP_1_2 = {2'b00, 2'b00, 2'b11};
  localparam logic [5:0] KEEP_2_3 = {2'b00, 2'b10, 2'b11};
  localparam logic [5:0] KEEP_3_4 = {2'b01, 2'b10, 2'b11};
  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef CONV_TAIL_INSERT_EN
    TAIL,
`endif
    DRAIN
  } state_t;
  function automatic logic [1:0] keep_mask(input logic [1:0] r, input logic [1:0] p);
    logic [5:0] m;
    m = r == RATE_3_4 ? KEEP_3_4 : r == RATE_2_3 ? KEEP_2_3 : KEEP_1_2;
    return m[{p, 1'b0} +: 2];
  endfunction
  function automatic logic [1:0] phase_max(input logic [1:0] r);
    return r == RATE_3_4 ? 2'd2 : r == RATE_2_3 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/conv_core.sv
// conv_core: K=7 shift register and generator A/B parity for the current input bit.
module conv_core
  import wifi_tx_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  input  logic din,
  output logic a,
  output logic b
);
  logic [5:0] s;
  logic [6:0] v;
  // s[0] is the most recent bit, so the tap vector reverses s
  assign v = {din, s[0], s[1], s[2], s[3], s[4], s[5]};
  assign a = ^(v & G0);
  assign b = ^(v & G1);
  always_ff @(posedge clk)
    if (!rst_n || clr) s <= '0;
    else if (adv) s <= {s[4:0], din};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: 802.11a K=7 rate-1/2 encoder punctured to 2/3 and 3/4, serial coded output.
// CONV_TAIL_INSERT_EN makes the encoder append TAIL_BITS zero tail bits itself.
module conv_encoder
  import wifi_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] rate,
  input  logic       in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);
  state_t state, state_nx;
  logic [1:0] rate_q, phase;
  logic sec_valid, sec_data, sec_last;
  logic a, b, ka, kb, din, adv, slot, pop, last_in;
  assign pop = out_valid && out_ready;
  // a new input may land only if the buffer drains to empty this cycle
  assign slot = !out_valid || (!sec_valid && out_ready);
  assign in_ready = !start && state == RUN && slot;
`ifdef CONV_TAIL_INSERT_EN
  logic [2:0] tail_cnt;
  assign adv = (in_ready && in_valid) || (!start && state == TAIL && slot);
  assign din = state == TAIL ? 1'b0 : in_data;
  assign last_in = state == TAIL && tail_cnt == 3'(TAIL_BITS - 1);
`else
  assign adv = in_ready && in_valid;
  assign din = in_data;
  assign last_in = in_last;
`endif
  assign {ka, kb} = keep_mask(rate_q, phase);
  conv_core u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .adv  (adv),
    .din  (din),
    .a    (a),
    .b    (b)
  );
  always_comb begin
    state_nx = state;
    if (start) state_nx = RUN;
    else if (state == RUN && adv && in_last)
`ifdef CONV_TAIL_INSERT_EN
      state_nx = TAIL;
    else if (state == TAIL && adv && last_in)
`endif
      state_nx = DRAIN;
    else if (state == DRAIN && pop && out_last) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rate_q    <= RATE_1_2;
      phase     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_last  <= 1'b0;
      sec_valid <= 1'b0;
      sec_data  <= 1'b0;
      sec_last  <= 1'b0;
`ifdef CONV_TAIL_INSERT_EN
      tail_cnt  <= 3'd0;
`endif
    end else begin
      state <= state_nx;
      if (start) begin
        rate_q    <= rate == RATE_3_4 || rate == RATE_2_3 ? rate : RATE_1_2;
        phase     <= 2'd0;
        out_valid <= 1'b0;
        out_data  <= 1'b0;
        out_last  <= 1'b0;
        sec_valid <= 1'b0;
        sec_last  <= 1'b0;
`ifdef CONV_TAIL_INSERT_EN
        tail_cnt  <= 3'd0;
`endif
      end else if (adv) begin
        phase     <= phase == phase_max(rate_q) ? 2'd0 : phase + 2'd1;
        out_valid <= 1'b1;
        out_data  <= ka ? a : b;
        out_last  <= last_in && !(ka && kb);
        sec_valid <= ka && kb;
        sec_data  <= b;
        sec_last  <= last_in && ka && kb;
`ifdef CONV_TAIL_INSERT_EN
        tail_cnt  <= state == TAIL ? tail_cnt + 3'd1 : 3'd0;
`endif
      end else if (pop) begin
        out_valid <= sec_valid;
        out_data  <= sec_valid && sec_data;
        out_last  <= sec_last;
        sec_valid <= 1'b0;
        sec_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: scoreboard bench for conv_encoder; a tap-list reference model queues expected bits.
// Follows CONV_TAIL_INSERT_EN to choose tail handling.
module tb_conv_encoder;
  import wifi_tx_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, in_data = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [1:0] rate = 2'b00;
  logic in_ready, out_data, out_valid, out_last;
  int n_checks = 0, n_fail = 0, n_exp = 0, n_got = 0, bp_mode = 0, bp_i = 0, m_ph = 0;
  logic [1:0] exp_q[$];
  logic [6:0] hist = '0;
  logic [1:0] m_rate = 2'b00;
  logic [63:0] got = '0;
  logic prev_stall = 0, prev_data = 0, prev_last = 0;

  conv_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rate     (rate),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // hist[k] is the input k bits ago; 133 taps delays 0,2,3,5,6 and 171 taps 0,1,2,3,6
  task automatic model_bit(input logic d, input logic last);
    logic a, b, ka, kb;
    hist = {hist[5:0], d};
    a = hist[0] ^ hist[2] ^ hist[3] ^ hist[5] ^ hist[6];
    b = hist[0] ^ hist[1] ^ hist[2] ^ hist[3] ^ hist[6];
    ka = m_ph != 2;
    kb = m_ph == 0 || m_ph == 2;
    if (ka) begin exp_q.push_back({a, last && !kb}); n_exp++; end
    if (kb) begin exp_q.push_back({b, last}); n_exp++; end
    m_ph = (m_ph + 1) % (m_rate == 2'b10 ? 3 : m_rate == 2'b01 ? 2 : 1);
  endtask

  task automatic do_start(input logic [1:0] r);
    @(posedge clk); #1;
    start = 1; rate = r;
    hist = '0; m_ph = 0; m_rate = r == 2'b11 ? 2'b00 : r;
    exp_q.delete(); n_exp = 0; n_got = 0; got = '0;
    @(posedge clk); #1;
    start = 0; rate = ~r;
  endtask

  task automatic send(input logic d, input logic last);
    int t = 0;
    in_valid = 1; in_data = d; in_last = last;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    else begin
`ifdef CONV_TAIL_INSERT_EN
      model_bit(d, 1'b0);
      if (last) for (int i = 0; i < TAIL_BITS; i++) model_bit(1'b0, i == TAIL_BITS - 1);
`else
      model_bit(d, last);
`endif
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin @(posedge clk); t++; end
    #1;
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // one impulse frame whose coded stream is 11 01 11 11 00 10 11 at rate 1/2
  task automatic impulse(input string tag);
`ifdef CONV_TAIL_INSERT_EN
    send(1'b1, 1'b1);
`else
    send(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b0, i == 5);
`endif
    for (int i = 0; i < 4; i++) begin @(negedge clk); check({tag, "_ready_after_last"}, in_ready, 0); end
    wait_drain(tag);
    check({tag, "_stream"}, got[13:0], 64'b11011111001011);
    check({tag, "_count"}, n_got, 14);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = bp_mode == 1 ? (bp_i % 4 == 0 || bp_i % 4 == 3) : bp_mode == 0;
    if (bp_mode == 1) bp_i++;
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_last", out_last, prev_last);
    end
    if (rst_n && out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
    prev_stall <= rst_n && out_valid && !out_ready && !start;
    prev_data <= out_data;
    prev_last <= out_last;
    if (rst_n && out_valid && out_ready) begin
      check("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[1]);
        check("out_last", out_last, e[0]);
        got <= {got[62:0], out_data};
        n_got <= n_got + 1;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    do_start(2'b00);
    impulse("imp12");

`ifndef CONV_TAIL_INSERT_EN
    do_start(2'b10);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b1);
    wait_drain("r34");
    check("r34_stream", got[3:0], 64'b1101);
    check("r34_count", n_got, 4);

    do_start(2'b01);
    send(1'b1, 1'b0); send(1'b0, 1'b1);
    wait_drain("r23");
    check("r23_stream", got[2:0], 64'b110);
    check("r23_count", n_got, 3);
`else
    do_start(2'b01);
    send(1'b1, 1'b0); send(1'b0, 1'b1);
    wait_drain("r23");
`endif

    do_start(2'b00);
    bp_mode = 1; bp_i = 0;
    for (int i = 0; i < 24; i++) send(1'($urandom_range(0, 1)), i == 23);
    wait_drain("bp");
    check("bp_count", n_got, n_exp);
    bp_mode = 0;

    do_start(2'b10);
    for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), 1'b0);
    rst_n = 0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1; exp_q.delete();
    @(posedge clk); #1;
    check("midrst_idle", in_ready, 0);

    do_start(2'b01);
    bp_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    do_start(2'b00);
    check("drain_flush", out_valid, 0);
    bp_mode = 0;
    impulse("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
